// File: rtl/food.sv
// Food-cell position generator for the snake game: a free-running 16-bit LFSR is sampled on
// each rising edge of food_eaten. Optional macro FOOD_NO_REPEAT_EN retries until the cell moves.
module food #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned SEGMENT_SIZE = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned INIT_X       = 320,
    parameter int unsigned INIT_Y       = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       food_eaten,
    output logic [9:0] food_x,
    output logic [9:0] food_y
);

    localparam int unsigned NCOL     = SCREEN_W / SEGMENT_SIZE;
    localparam int unsigned NROW     = SCREEN_H / SEGMENT_SIZE;
    localparam logic [6:0]  NColL    = 7'(NCOL);
    localparam logic [6:0]  NRowL    = 7'(NROW);
    // A 6-bit source never needs more subtractions than this to drop below the grid size.
    localparam int          ColFolds = 64 / NCOL;
    localparam int          RowFolds = 64 / NROW;

    logic [15:0] lfsr_q, lfsr_d;
    logic        eaten_q;
    logic        armed_q, armed_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [6:0]  col, row;
    logic [9:0]  cand_x, cand_y;
    logic        update;

    function automatic logic [9:0] to_pixel(input logic [6:0] n);
        logic [9:0] w;
        w = {3'b000, n};
        if (SEGMENT_SIZE == 10) begin
            return (w << 3) + (w << 1);
        end
        return 10'(w * SEGMENT_SIZE);
    endfunction

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (lfsr_d == 16'h0000) begin
            lfsr_d = 16'h0001;
        end
    end

    always_comb begin
        col = {1'b0, lfsr_q[5:0]};
        for (int i = 0; i < ColFolds; i++) begin
            if (col >= NColL) begin
                col = col - NColL;
            end
        end
    end

    always_comb begin
        row = {1'b0, lfsr_q[13:8]};
        for (int i = 0; i < RowFolds; i++) begin
            if (row >= NRowL) begin
                row = row - NRowL;
            end
        end
    end

    assign cand_x = to_pixel(col);
    assign cand_y = to_pixel(row);

    // armed_q blocks a level that was already high when reset released from counting as an edge.
    assign update  = food_eaten & ~eaten_q & armed_q;
    assign armed_d = armed_q | ~food_eaten;

`ifdef FOOD_NO_REPEAT_EN
    logic pending_q, pending_d;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        pending_d = pending_q;
        if (update || pending_q) begin
            if (cand_x == x_q && cand_y == y_q) begin
                pending_d = 1'b1;
            end else begin
                x_d       = cand_x;
                y_d       = cand_y;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (update) begin
            x_d = cand_x;
            y_d = cand_y;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q  <= LFSR_SEED;
            eaten_q <= 1'b0;
            armed_q <= 1'b0;
            x_q     <= 10'(INIT_X);
            y_q     <= 10'(INIT_Y);
        end else begin
            lfsr_q  <= lfsr_d;
            eaten_q <= food_eaten;
            armed_q <= armed_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign food_x = x_q;
    assign food_y = y_q;

endmodule

// File: tb/tb_food.sv
// Self-checking bench for food: a reference model pushes each expected position into a
// scoreboard queue; checks run on the falling edge, opposite the active clock edge.
module tb_food;

    logic       clk = 1'b0;
    logic       reset;
    logic       food_eaten;
    logic [9:0] food_x;
    logic [9:0] food_y;

    food dut (
        .clk       (clk),
        .reset     (reset),
        .food_eaten(food_eaten),
        .food_x    (food_x),
        .food_y    (food_y)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

    typedef struct {
        logic [11:0] pat;
        int          len;
        int          exp_upd;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    pos_t exp_q[$];

    function automatic pos_t cand(input logic [15:0] l);
        int   c;
        int   r;
        pos_t p;
        c = int'(l[5:0]);
        r = int'(l[13:8]);
        while (r >= 48) r -= 48;
        p.x = 10'(c * 10);
        p.y = 10'(r * 10);
        return p;
    endfunction

    // Reference model, written from the behavioural description.
    logic [15:0] m_lfsr;
    logic        m_prev, m_armed, due;
    logic [9:0]  m_x, m_y;
    int          m_nsame = 0;
    logic        m_upd, m_load;
    pos_t        m_c;

    assign m_upd = food_eaten & ~m_prev & m_armed;
    assign m_c   = cand(m_lfsr);

`ifdef FOOD_NO_REPEAT_EN
    logic m_pend;
    assign m_load = (m_upd | m_pend) && (m_c != {m_x, m_y});
`else
    assign m_load = m_upd;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr  <= 16'hACE1;
            m_prev  <= 1'b0;
            m_armed <= 1'b0;
            m_x     <= 10'd320;
            m_y     <= 10'd240;
            due     <= 1'b0;
`ifdef FOOD_NO_REPEAT_EN
            m_pend  <= 1'b0;
`endif
            exp_q.delete();
        end else begin
            m_lfsr  <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            m_prev  <= food_eaten;
            m_armed <= m_armed | ~food_eaten;
            due     <= m_load;
            if (m_load) begin
                m_x <= m_c.x;
                m_y <= m_c.y;
                exp_q.push_back(m_c);
            end
            if (m_load && m_c == {m_x, m_y}) m_nsame <= m_nsame + 1;
`ifdef FOOD_NO_REPEAT_EN
            m_pend <= (m_upd | m_pend) && (m_c == {m_x, m_y});
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [19:0] last;
    int          chg = 0;
    pos_t        seen[$];
    bit          log_seen = 1'b0;

    // One clock: wait for the falling edge, then score whatever the DUT produced.
    task automatic tick();
        pos_t e;
        @(negedge clk);
        if (due) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got output 0x%0h, expected no update", {food_x, food_y});
            end else begin
                e = exp_q.pop_front();
                check("sb_pos", 32'({food_x, food_y}), 32'(e));
                check("x_range", 32'(food_x < 10'd640), 32'd1);
                check("y_range", 32'(food_y < 10'd480), 32'd1);
                check("x_grid", 32'(food_x % 10), 32'd0);
                check("y_grid", 32'(food_y % 10), 32'd0);
                if (log_seen) seen.push_back({food_x, food_y});
            end
        end else begin
            check("hold", 32'({food_x, food_y}), 32'({m_x, m_y}));
        end
        if ({food_x, food_y} != last) chg++;
        last = {food_x, food_y};
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   c0, s0, ndist, found;
        bit   dup;

        vecs[0] = '{pat: 12'b0000_0000_0001, len: 4,  exp_upd: 1};
        vecs[1] = '{pat: 12'b0000_0000_1111, len: 6,  exp_upd: 1};
        vecs[2] = '{pat: 12'b0000_0101_0101, len: 8,  exp_upd: 4};
        vecs[3] = '{pat: 12'b0000_0110_0110, len: 8,  exp_upd: 2};
        vecs[4] = '{pat: 12'b0000_0000_0000, len: 6,  exp_upd: 0};
        vecs[5] = '{pat: 12'b1011_0011_1001, len: 12, exp_upd: 4};

        food_eaten = 1'b0;
        reset      = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_x", 32'(food_x), 32'd320);
        check("rst_y", 32'(food_y), 32'd240);
        check("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        #9 reset = 1'b0;
        #1 check("rst_lfsr_hold", 32'(dut.lfsr_q), 32'h0000ACE1);
        last = {food_x, food_y};
        repeat (3) tick();

        // Single one-cycle pulse: update visible one edge later.
        food_eaten = 1'b1;
        tick();
        check("single_due", 32'(due), 32'd1);
        food_eaten = 1'b0;
        repeat (2) tick();

        // 15 pulses with two idle cycles between them.
        log_seen = 1'b1;
        for (int p = 0; p < 15; p++) begin
            food_eaten = 1'b1;
            tick();
            food_eaten = 1'b0;
            repeat (2) tick();
        end
        log_seen = 1'b0;
        ndist = 0;
        for (int i = 0; i < seen.size(); i++) begin
            dup = 1'b0;
            for (int j = 0; j < i; j++) if (seen[j] == seen[i]) dup = 1'b1;
            if (!dup) ndist++;
        end
        check("pulses_logged", 32'(seen.size()), 32'd15);
        check("distinct_ge2", 32'(ndist >= 2), 32'd1);

        // Table of food_eaten waveforms, LSB applied first, with expected update counts.
        for (int v = 0; v < 6; v++) begin
            c0 = chg;
            s0 = m_nsame;
            for (int b = 0; b < vecs[v].len; b++) begin
                food_eaten = vecs[v].pat[b];
                tick();
            end
            food_eaten = 1'b0;
            repeat (4) tick();
            check($sformatf("vec%0d_updates", v), 32'((chg - c0) + (m_nsame - s0)),
                  32'(vecs[v].exp_upd));
        end

        // Level held high for 10 cycles gives exactly one update.
        c0 = chg;
        s0 = m_nsame;
        food_eaten = 1'b1;
        repeat (10) tick();
        food_eaten = 1'b0;
        repeat (3) tick();
        check("hold_high_one", 32'((chg - c0) + (m_nsame - s0)), 32'd1);

        // Wait for LFSR bits [13:8] == 63 and fire on it: row folds to 15.
        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            tick();
            if (m_lfsr[13:8] == 6'd63) begin
                found = 1;
                food_eaten = 1'b1;
                tick();
                food_eaten = 1'b0;
                check("fold_y", 32'(food_y), 32'd150);
                tick();
            end
        end
        if (found == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fold_search: got no row-63 state, expected one within budget");
        end

        // Reset mid-request wins; a level high across release is not an edge.
        food_eaten = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("rst_mid_x", 32'(food_x), 32'd320);
        check("rst_mid_y", 32'(food_y), 32'd240);
        tick();
        #2 reset = 1'b0;
        repeat (4) tick();
        check("rel_high_x", 32'(food_x), 32'd320);
        check("rel_high_y", 32'(food_y), 32'd240);
        food_eaten = 1'b0;
        tick();
        food_eaten = 1'b1;
        tick();
        check("rel_edge_due", 32'(due), 32'd1);
        food_eaten = 1'b0;
        repeat (2) tick();

`ifdef FOOD_NO_REPEAT_EN
        found = 0;
        for (int i = 0; i < 40000 && found == 0; i++) begin
            tick();
            if (m_c == {m_x, m_y}) begin
                logic [19:0] old;
                bit          moved;
                found = 1;
                old = {food_x, food_y};
                food_eaten = 1'b1;
                tick();
                food_eaten = 1'b0;
                moved = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if ({food_x, food_y} != old) moved = 1'b1;
                    tick();
                end
                check("norepeat_moved", 32'(moved), 32'd1);
            end
        end
        if (found == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL norepeat_search: got no colliding state, expected one within budget");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
